// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_sync_decoder: recovers x/y/de/pixel from an active-low HS/VS/RGB stream
// and measures line/frame lengths to report lock.     Revision: 1.0
// ----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        HS,
  input  logic        VS,
  input  logic [11:0] Din,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic [11:0] dout,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [9:0]  line_len
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int          GW        = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0]  CNT_MAX   = 10'h3FF;
  localparam logic [9:0]  H_TOT     = 10'(H_TOTAL);
  localparam logic [9:0]  V_TOT     = 10'(V_TOTAL);
  localparam logic [9:0]  HX0       = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  HX1       = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  VY0       = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VY1       = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

  state_t          state_q, state_d;
  logic            hs_q, hs_d, vs_q, vs_d, vpend_q, vpend_d;
  logic [9:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d, line_len_q, line_len_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [11:0]     dout_q, dout_d;
  logic            de_q, de_d, frame_start_q, frame_start_d;
  logic            locked_q, locked_d, sync_err_q, sync_err_d;
  logic            lines_ok_q, lines_ok_d;
  logic [GW-1:0]   good_q, good_d, good_inc;
  logic            hfall, vfall, frame, line_good, frame_good, in_win;
  logic [9:0]      hcnt_inc, vcnt_inc;

  // hcnt_d/vcnt_d are the counter values of the current sample cycle
  always_comb begin
    hs_d       = HS;
    vs_d       = VS;
    hfall      = hs_q & ~HS;
    vfall      = vs_q & ~VS;
    frame      = hfall & (vpend_q | vfall);
    hcnt_inc   = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1;
    vcnt_inc   = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + 10'd1;
    line_good  = (hcnt_inc == H_TOT);
    frame_good = (vcnt_inc == V_TOT);
    hcnt_d     = hfall ? 10'd0 : hcnt_inc;
    vcnt_d     = vcnt_q;
    if (frame) begin
      vcnt_d = 10'd0;
    end else if (hfall) begin
      vcnt_d = vcnt_inc;
    end
    vpend_d       = hfall ? 1'b0 : (vpend_q | vfall);
    line_len_d    = hfall ? hcnt_inc : line_len_q;
    frame_start_d = frame;
    in_win = (hcnt_d >= HX0) && (hcnt_d <= HX1) && (vcnt_d >= VY0) && (vcnt_d <= VY1);
    de_d   = in_win & locked_q;
    x_d    = x_q;
    y_d    = y_q;
    dout_d = dout_q;
    if (in_win) begin
      x_d    = hcnt_d - HX0;
      y_d    = vcnt_d - VY0;
      dout_d = Din;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    lines_ok_d = lines_ok_q;
    locked_d   = 1'b0;
    sync_err_d = 1'b0;
    good_inc   = good_q + 1'b1;
    case (state_q)
      SEARCH: begin
        if (frame) begin
          state_d    = TRACK;
          good_d     = '0;
          lines_ok_d = 1'b1;
        end
      end
      TRACK: begin
        if (hfall && !line_good) lines_ok_d = 1'b0;
        if (frame) begin
          lines_ok_d = 1'b1;
          if (frame_good && lines_ok_q && line_good) begin
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        locked_d = 1'b1;
        if ((hfall && !line_good) || (frame && !frame_good) ||
            (hcnt_d == H_TOT) || (vcnt_d == V_TOT)) begin
          state_d    = SEARCH;
          locked_d   = 1'b0;
          sync_err_d = 1'b1;
          good_d     = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      vpend_q       <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_len_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
      dout_q        <= '0;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      lines_ok_q    <= 1'b0;
      good_q        <= '0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      vpend_q       <= vpend_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dout_q        <= dout_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      lines_ok_q    <= lines_ok_d;
      good_q        <= good_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign dout        = dout_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign line_len    = line_len_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_sync_decoder: directed-frame bench for vga_sync_decoder on a reduced
// 20x10 timing with a pixel scoreboard.               Revision: 1.0
// ----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HS_W  = 4;
  localparam int HBP   = 3;
  localparam int HACT  = 8;
  localparam int HT    = 20;
  localparam int VS_W  = 2;
  localparam int VBP   = 2;
  localparam int VACT  = 4;
  localparam int VT    = 10;
  localparam int HX0   = HS_W + HBP;
  localparam int HX1   = HS_W + HBP + HACT - 1;
  localparam int VY0   = VS_W + VBP;
  localparam int VY1   = VS_W + VBP + VACT - 1;

  logic        clk, RSTN, HS, VS;
  logic [11:0] Din, dout;
  logic [9:0]  x, y, line_len;
  logic        de, frame_start, locked, sync_err;

  vga_sync_decoder #(
    .H_SYNC(HS_W), .H_BP(HBP), .H_ACTIVE(HACT), .H_TOTAL(HT),
    .V_SYNC(VS_W), .V_BP(VBP), .V_ACTIVE(VACT), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .RSTN(RSTN), .HS(HS), .VS(VS), .Din(Din),
    .x(x), .y(y), .de(de), .dout(dout),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .line_len(line_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc_n = 0;
  int          n_err = 0;
  int          err_cyc = 0;
  int          err_len = 0;
  int          fs_len = 0;
  int          lock_cyc = 0;
  int          de_cnt = 0;
  int          de_base = 0;
  int          stuck_start = 0;
  logic        prev_locked = 1'b0;
  int          fs_q[$];
  logic [31:0] sb_q[$];
  logic [31:0] sb_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // One pixel clock: drive inputs, let the DUT sample, then log observed events
  task automatic cyc(input logic hs, input logic vs, input logic [11:0] d);
    HS  = hs;
    VS  = vs;
    Din = d;
    @(posedge clk);
    #1;
    cyc_n++;
    if (frame_start) begin
      fs_q.push_back(cyc_n);
      fs_len = int'(line_len);
    end
    if (sync_err) begin
      n_err++;
      err_cyc = cyc_n;
      err_len = int'(line_len);
    end
    if (locked && !prev_locked) lock_cyc = cyc_n;
    prev_locked = locked;
  endtask

  // offs=1 drops VS 10 clocks into line 0, so the decoder's row 0 is generator line 1
  task automatic drive_frame(input int nlines, input int short_line, input int de_last,
                             input bit offs, input int rst_line);
    int voff, len, p, dl;
    logic [11:0] din_v;
    bit rst_now;
    voff = offs ? 10 : 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        p     = l * HT + c;
        dl    = offs ? l - 1 : l;
        din_v = 12'($urandom_range(0, 4095));
        if (l <= de_last && dl >= VY0 && dl <= VY1 && c >= HX0 && c <= HX1)
          sb_q.push_back({10'(c - HX0), 10'(dl - VY0), din_v});
        rst_now = (l == rst_line) && (c == 5);
        if (rst_now) begin
          chk("locked_before_reset", 64'(locked), 64'd1);
          RSTN = 1'b0;
        end
        cyc(c >= HS_W, !(p >= voff && p < voff + VS_W * HT), din_v);
        if (rst_now) begin
          RSTN = 1'b1;
          chk("reset_mid_outputs",
              64'({x, y, de, dout, frame_start, locked, sync_err, line_len}), 64'd0);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (de) begin
      de_cnt++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_de", 64'({x, y, dout}), 64'hFFFF_FFFF_FFFF);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_pixel", 64'({x, y, dout}), 64'(sb_e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    RSTN = 1'b0;
    HS   = 1'b1;
    VS   = 1'b1;
    Din  = 12'd0;
    repeat (3) cyc(1'b1, 1'b1, 12'd0);
    chk("reset_outputs", 64'({x, y, de, dout, frame_start, locked, sync_err, line_len}), 64'd0);
    RSTN = 1'b1;
    repeat (5) cyc(1'b1, 1'b1, 12'd0);

    // Nominal: lock one cycle after the 3rd frame_start, full frame of pixels after
    drive_frame(VT, -1, -1, 1'b0, -1);
    drive_frame(VT, -1, -1, 1'b0, -1);
    drive_frame(VT, -1, 99, 1'b0, -1);
    de_base = de_cnt;
    drive_frame(VT, -1, 99, 1'b0, -1);
    chk("nom_fs_count",   64'(fs_q.size()), 64'd4);
    chk("nom_fs_period",  64'(fs_q[1] - fs_q[0]), 64'(HT * VT));
    chk("nom_lock_cycle", 64'(lock_cyc), 64'(fs_q[2] + 1));
    chk("nom_de_count",   64'(de_cnt - de_base), 64'(HACT * VACT));
    chk("nom_no_err",     64'(n_err), 64'd0);
    chk("nom_line_len",   64'(line_len), 64'(HT));
    chk("nom_sb_drained", 64'(sb_q.size()), 64'd0);

    // One short line while locked
    drive_frame(VT, 6, 6, 1'b0, -1);
    chk("short_err_count", 64'(n_err), 64'd1);
    chk("short_err_cycle", 64'(err_cyc), 64'(fs_q[4] + 6 * HT + (HT - 1)));
    chk("short_line_len",  64'(err_len), 64'(HT - 1));
    chk("short_unlocked",  64'(locked), 64'd0);
    drive_frame(VT, -1, -1, 1'b0, -1);
    drive_frame(VT, -1, -1, 1'b0, -1);
    drive_frame(VT, -1, 99, 1'b0, -1);
    chk("short_relock_cycle", 64'(lock_cyc), 64'(fs_q[7] + 1));
    chk("short_sb_drained",   64'(sb_q.size()), 64'd0);

    // HS stuck high while locked: timeout at hcnt=HT, then saturated line_len
    drive_frame(3, -1, -1, 1'b0, -1);
    stuck_start = cyc_n + 1;
    repeat (1100) cyc(1'b1, 1'b1, 12'd0);
    chk("stuck_err_count", 64'(n_err), 64'd2);
    chk("stuck_err_cycle", 64'(err_cyc), 64'(stuck_start));
    chk("stuck_err_len",   64'(err_len), 64'(HT));
    chk("stuck_unlocked",  64'(locked), 64'd0);
    chk("stuck_len_hold",  64'(line_len), 64'(HT));

    // First judged frame one line short: lock slips to the 4th frame_start
    drive_frame(VT - 1, -1, -1, 1'b0, -1);
    chk("stuck_len_sat", 64'(fs_len), 64'd1023);
    drive_frame(VT, -1, -1, 1'b0, -1);
    drive_frame(VT, -1, -1, 1'b0, -1);
    drive_frame(VT, -1, 99, 1'b0, -1);
    chk("shortframe_lock_cycle", 64'(lock_cyc), 64'(fs_q[12] + 1));
    chk("shortframe_no_err",     64'(n_err), 64'd2);

    // Mid-frame reset while locked, then relock with VS lagging HS by 10 clocks
    drive_frame(VT, -1, -1, 1'b0, 2);
    chk("reset_no_err", 64'(n_err), 64'd2);
    drive_frame(VT, -1, -1, 1'b1, -1);
    drive_frame(VT, -1, -1, 1'b1, -1);
    drive_frame(VT, -1, 99, 1'b1, -1);
    chk("offset_first_fs",     64'(fs_q[14] - fs_q[13]), 64'(HT * VT + HT));
    chk("offset_fs_period",    64'(fs_q[16] - fs_q[15]), 64'(HT * VT));
    chk("offset_relock_cycle", 64'(lock_cyc), 64'(fs_q[16] + 1));
    chk("final_sb_drained",    64'(sb_q.size()), 64'd0);
    chk("final_fs_count",      64'(fs_q.size()), 64'd17);
    chk("final_no_err",        64'(n_err), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
